// File: rtl/param_ctrl_regs_if.sv
// Command bus plus per-channel sideband shared between the register host and the register block.
// Latency: none, this is a plain bundle of wires.
// Backpressure: none, every command is accepted in the cycle it is presented.
interface param_ctrl_regs_if #(
   parameter int NUM_SLV = 3,
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int AVW     = 8
);
   logic [1:0]             cmd;
   logic [AW-1:0]          cmd_addr;
   logic [DW-1:0]          cmd_data_i;
   logic [DW-1:0]          cmd_data_o;
   logic [NUM_SLV*AVW-1:0] slv_avail;
   logic [NUM_SLV*3-1:0]   slv_len;
   logic [NUM_SLV*2-1:0]   slv_prio;
   logic [NUM_SLV-1:0]     slv_en;

   // The host issues commands and reports FIFO free space.
   modport master (
      output cmd, cmd_addr, cmd_data_i, slv_avail,
      input  cmd_data_o, slv_len, slv_prio, slv_en
   );

   // The register block decodes commands and drives the channel controls.
   modport slave (
      input  cmd, cmd_addr, cmd_data_i, slv_avail,
      output cmd_data_o, slv_len, slv_prio, slv_en
   );
endinterface

// File: rtl/param_ctrl_regs.sv
// Per-channel control/status register file with a global lock and sticky error bit.
// Latency: reads return data one cycle after the RD is sampled; writes take effect on that same edge.
// Backpressure: none, a command is consumed every cycle; illegal accesses only raise err.
module param_ctrl_regs #(
   parameter int NUM_SLV = 3,
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int AVW     = 8
) (
   input logic              clk,
   input logic              rstn,
   param_ctrl_regs_if.slave bus
);

   localparam logic [1:0] CMD_WR = 2'b10;
   localparam logic [1:0] CMD_RD = 2'b01;

   logic [5:0]     r_ctrl  [NUM_SLV];
   logic [AVW-1:0] r_avail [NUM_SLV];
   logic           r_lock;
   logic           r_err;
   logic [DW-1:0]  r_rdata;

   logic [31:0]    w_addr;
   logic [3:0]     w_idx;
   logic           w_rd;
   logic           w_wr;
   logic           w_ctrl_rgn;
   logic           w_stat_rgn;
   logic           w_ctrl_hit;
   logic           w_stat_hit;
   logic           w_glb_hit;
   logic [5:0]     w_ctrl_sel;
   logic [AVW-1:0] w_avail_sel;
   logic [DW-1:0]  w_rd_dat;
   logic           w_err_set;
   logic           w_err_clr;

   // cmd=11 decodes as neither RD nor WR, so it has no side effect at all.
   assign w_rd   = (bus.cmd == CMD_RD);
   assign w_wr   = (bus.cmd == CMD_WR);
   assign w_addr = 32'(bus.cmd_addr);
   assign w_idx  = w_addr[5:2];

   // Word-aligned windows: 0x00-0x3F control, 0x40-0x7F status.
   assign w_ctrl_rgn = (w_addr[31:6] == 26'd0) && (w_addr[1:0] == 2'b00);
   assign w_stat_rgn = (w_addr[31:6] == 26'd1) && (w_addr[1:0] == 2'b00);
   assign w_glb_hit  = (w_addr == 32'h0000_0080);

   // Select the addressed channel; indices beyond NUM_SLV never hit and so fall out as unmapped.
   always_comb begin
      w_ctrl_hit  = 1'b0;
      w_stat_hit  = 1'b0;
      w_ctrl_sel  = '0;
      w_avail_sel = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (w_idx == 4'(i)) begin
            w_ctrl_hit  = w_ctrl_rgn;
            w_stat_hit  = w_stat_rgn;
            w_ctrl_sel  = r_ctrl[i];
            w_avail_sel = r_avail[i];
         end
      end
   end

   // Read data mux; unmapped reads return zero.
   always_comb begin
      w_rd_dat = '0;
      if (w_ctrl_hit)      w_rd_dat = DW'(w_ctrl_sel);
      else if (w_stat_hit) w_rd_dat = DW'(w_avail_sel);
      else if (w_glb_hit)  w_rd_dat = DW'({r_err, r_lock});
   end

   // A locked CTRL write is a mapped target, so it is silently dropped rather than flagged.
   assign w_err_set = (w_rd && !(w_ctrl_hit || w_stat_hit || w_glb_hit)) ||
                      (w_wr && !(w_ctrl_hit || w_glb_hit));
   assign w_err_clr = w_rd && w_glb_hit;

   // Channel control registers, writable only while unlocked.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_SLV; i++) r_ctrl[i] <= 6'h07;
      end else if (w_wr && w_ctrl_hit && !r_lock) begin
         for (int i = 0; i < NUM_SLV; i++) begin
            if (w_idx == 4'(i)) r_ctrl[i] <= bus.cmd_data_i[5:0];
         end
      end
   end

   // Free-space shadow sampled every cycle so STAT reads are stable and one cycle behind the input.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_SLV; i++) r_avail[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SLV; i++) r_avail[i] <= bus.slv_avail[i*AVW +: AVW];
      end
   end

   // Global lock, sticky err (set beats read-clear), and the registered read port.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_lock  <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (w_wr && w_glb_hit) r_lock <= bus.cmd_data_i[0];
         if (w_err_set)         r_err  <= 1'b1;
         else if (w_err_clr)    r_err  <= 1'b0;
         if (w_rd)              r_rdata <= w_rd_dat;
      end
   end

   assign bus.cmd_data_o = r_rdata;

   for (genvar g = 0; g < NUM_SLV; g++) begin : g_out
      assign bus.slv_en[g]          = r_ctrl[g][0];
      assign bus.slv_prio[2*g +: 2] = r_ctrl[g][2:1];
      assign bus.slv_len[3*g +: 3]  = r_ctrl[g][5:3];
   end

endmodule

// File: tb/tb_param_ctrl_regs.sv
// Directed bench for param_ctrl_regs with a read-data scoreboard queue.
// Latency: expects read data one cycle after each RD.
// Backpressure: none exercised, the block has none.
module tb_param_ctrl_regs;

   localparam int NUM_SLV = 3;
   localparam int AW      = 8;
   localparam int DW      = 32;
   localparam int AVW     = 8;

   logic clk;
   logic rstn;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [31:0] exp_q [$];

   param_ctrl_regs_if #(.NUM_SLV(NUM_SLV), .AW(AW), .DW(DW), .AVW(AVW)) bus ();

   param_ctrl_regs #(.NUM_SLV(NUM_SLV), .AW(AW), .DW(DW), .AVW(AVW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One command cycle: drive at negedge, sampled at posedge, back to IDLE just after.
   task automatic cyc(input logic [1:0] c, input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.cmd        = c;
      bus.cmd_addr   = a;
      bus.cmd_data_i = d;
      @(posedge clk);
      #1;
      bus.cmd = 2'b00;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      cyc(2'b10, a, d);
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] e, input string tag);
      exp_q.push_back(e);
      cyc(2'b01, a, 32'h0);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $error("FAIL %s: observed empty scoreboard expected entry", tag);
      end else begin
         chk(tag, bus.cmd_data_o, exp_q.pop_front());
      end
   endtask

   task automatic chk_outs(input string tag, input logic [2:0] en, input logic [5:0] prio, input logic [8:0] len);
      chk({tag, "_en"},   32'(bus.slv_en),   32'(en));
      chk({tag, "_prio"}, 32'(bus.slv_prio), 32'(prio));
      chk({tag, "_len"},  32'(bus.slv_len),  32'(len));
   endtask

   initial begin
      rstn           = 1'b0;
      bus.cmd        = 2'b00;
      bus.cmd_addr   = '0;
      bus.cmd_data_i = '0;
      bus.slv_avail  = '0;

      // Reset, with a write presented during reset that must be ignored.
      cyc(2'b10, 8'h00, 32'h0000_0000);
      cyc(2'b00, 8'h00, 32'h0);
      chk("rst_rdata", bus.cmd_data_o, 32'h0);
      chk_outs("rst", 3'b111, 6'b111111, 9'b0);
      @(negedge clk);
      rstn = 1'b1;

      rd(8'h00, 32'h07, "rd_ctrl0_rst");
      rd(8'h04, 32'h07, "rd_ctrl1_rst");
      rd(8'h08, 32'h07, "rd_ctrl2_rst");
      rd(8'h80, 32'h00, "rd_glb_rst");

      // Field mapping of a CTRL write.
      wr(8'h04, 32'h0000_002A);
      chk_outs("wr_ctrl1", 3'b101, 6'b110111, 9'b000_101_000);
      rd(8'h04, 32'h2A, "rd_ctrl1_2a");
      wr(8'h08, 32'hFFFF_FFC7);
      chk("hold_after_wr", bus.cmd_data_o, 32'h2A);
      cyc(2'b00, 8'h08, 32'h0);
      chk("hold_after_idle", bus.cmd_data_o, 32'h2A);
      rd(8'h08, 32'h07, "rd_ctrl2_upper_discard");

      // Lock blocks CTRL writes without flagging err.
      wr(8'h80, 32'h1);
      wr(8'h00, 32'h0);
      chk_outs("locked", 3'b101, 6'b110111, 9'b000_101_000);
      rd(8'h80, 32'h1, "rd_glb_locked");
      wr(8'h80, 32'h0);
      wr(8'h00, 32'h0);
      chk_outs("unlocked", 3'b100, 6'b110100, 9'b000_101_000);
      wr(8'h80, 32'h2);
      rd(8'h80, 32'h0, "rd_glb_err_ro");

      // Avail shadow and STAT behaviour.
      bus.slv_avail = {8'h20, 8'h5A, 8'h11};
      cyc(2'b00, 8'h00, 32'h0);
      cyc(2'b00, 8'h00, 32'h0);
      rd(8'h48, 32'h20, "rd_stat2");
      rd(8'h44, 32'h5A, "rd_stat1");
      exp_q.push_back(32'h11);
      @(negedge clk);
      bus.slv_avail  = {8'h20, 8'h5A, 8'h33};
      bus.cmd        = 2'b01;
      bus.cmd_addr   = 8'h40;
      @(posedge clk);
      #1;
      bus.cmd = 2'b00;
      chk("rd_stat0_shadow_lag", bus.cmd_data_o, exp_q.pop_front());
      rd(8'h40, 32'h33, "rd_stat0_new");
      wr(8'h48, 32'hFF);
      rd(8'h48, 32'h20, "rd_stat2_after_wr");
      rd(8'h80, 32'h2, "rd_glb_err_stat_wr");
      rd(8'h80, 32'h0, "rd_glb_err_cleared");

      // Unmapped accesses.
      rd(8'h0C, 32'h0, "rd_ctrl3_unmapped");
      rd(8'h80, 32'h2, "rd_glb_err_unmapped_rd");
      rd(8'h80, 32'h0, "rd_glb_err_clear2");
      rd(8'h01, 32'h0, "rd_unaligned");
      rd(8'h80, 32'h2, "rd_glb_err_unaligned");
      wr(8'h84, 32'h1);
      rd(8'h80, 32'h2, "rd_glb_err_unmapped_wr");
      wr(8'h4C, 32'h1);
      rd(8'h80, 32'h2, "rd_glb_err_stat3_wr");

      // Reserved command: no write, no err.
      cyc(2'b11, 8'h00, 32'h3F);
      cyc(2'b11, 8'h0C, 32'h0);
      chk_outs("reserved", 3'b100, 6'b110100, 9'b000_101_000);
      rd(8'h80, 32'h0, "rd_glb_reserved_no_err");

      // Reset in the middle of a read discards the result.
      rd(8'h04, 32'h2A, "rd_ctrl1_before_rst");
      wr(8'h00, 32'h3F);
      chk_outs("pre_rst", 3'b101, 6'b110111, 9'b000_101_111);
      @(negedge clk);
      rstn         = 1'b0;
      bus.cmd      = 2'b01;
      bus.cmd_addr = 8'h04;
      @(posedge clk);
      #1;
      bus.cmd = 2'b00;
      chk("midrst_rdata", bus.cmd_data_o, 32'h0);
      chk_outs("midrst", 3'b111, 6'b111111, 9'b0);
      @(negedge clk);
      rstn = 1'b1;
      rd(8'h00, 32'h07, "rd_ctrl0_post_rst");
      rd(8'h04, 32'h07, "rd_ctrl1_post_rst");
      rd(8'h80, 32'h00, "rd_glb_post_rst");

      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/param_ctrl_regs.md
PARAM_CTRL_REGS -- requirements
Module: param_ctrl_regs

Interface
REQ-001 SHALL have parameter NUM_SLV, default 3, number of slave channels (legal 1..8).
REQ-002 SHALL have parameter AW, default 8, command address width.
REQ-003 SHALL have parameter DW, default 32, command data width (fixed 32 in this generation).
REQ-004 SHALL have parameter AVW, default 8, per-channel avail width (legal 1..DW).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 cmd  input  2  00 IDLE, 10 WR, 01 RD, 11 reserved (treated as IDLE).
REQ-008 cmd_addr  input  AW  byte address of accessed register.
REQ-009 cmd_data_i  input  DW  write data.
REQ-010 cmd_data_o  output  DW  registered read data.
REQ-011 slv_avail  input  NUM_SLV*AVW  packed per-channel FIFO free space; channel i at [i*AVW +: AVW].
REQ-012 slv_len  output  NUM_SLV*3  packed packet-length code per channel.
REQ-013 slv_prio  output  NUM_SLV*2  packed arbitration priority per channel.
REQ-014 slv_en  output  NUM_SLV  per-channel enable.

Function
REQ-015 Address map SHALL be: CTRL[i] at 0x00+4*i (RW), STAT[i] at 0x40+4*i (RO), GLB at 0x80 (RW); any other address is unmapped.
REQ-016 CTRL[i] SHALL be: bit0 en, bits2:1 prio, bits5:3 len, bits31:6 read 0, writes to them discarded.
REQ-017 STAT[i] SHALL be: bits AVW-1:0 = sampled avail of channel i, upper bits read 0.
REQ-018 GLB SHALL be: bit0 lock (RW), bit1 err (RO sticky), bits31:2 read 0.
REQ-019 slv_en/slv_prio/slv_len SHALL be driven directly from CTRL register bits (no combinational path from cmd).
REQ-020 A WR to CTRL[i] SHALL update the register on the same clock edge; new value on outputs the following cycle.
REQ-021 While lock=1, WR to any CTRL[i] SHALL be ignored without setting err; WR to GLB SHALL always be accepted.
REQ-022 slv_avail SHALL be registered every cycle into an avail shadow; STAT[i] reads return the shadow (one cycle behind input).
REQ-023 A RD SHALL load cmd_data_o on that edge: data visible the cycle after RD is sampled (latency 1).
REQ-024 cmd_data_o SHALL hold its last value during IDLE and WR cycles.
REQ-025 RD of unmapped address SHALL return 0 and set err; WR to unmapped address or to STAT[i] SHALL be discarded and set err.
REQ-026 RD of GLB SHALL return current err then clear err (read-to-clear).
REQ-027 If an err-setting event and err clear fall on the same edge, set SHALL win (err=1 afterwards).
REQ-028 CTRL/STAT for index i >= NUM_SLV SHALL be treated as unmapped.
REQ-029 cmd=11 SHALL have no side effect and SHALL NOT set err.

Reset
REQ-030 While rstn=0 at a rising edge: every CTRL[i] SHALL become 0x07 (en=1, prio=3, len=0).
REQ-031 While rstn=0: lock=0, err=0, avail shadow=0, cmd_data_o=0; commands in that cycle SHALL be ignored.
REQ-032 Reset asserted mid-sequence SHALL discard any pending read result; first post-reset RD returns reset values.

Verification
REQ-033 Reset then RD 0x00,0x04,0x08 (NUM_SLV=3) -> cmd_data_o=0x07 each, one cycle after each RD; slv_en=3'b111, slv_prio=6'b111111, slv_len=0.
REQ-034 WR 0x04 data 0x2A -> next cycle slv_en[1]=0, slv_prio[3:2]=2'b01, slv_len[5:3]=3'b101; RD 0x04 returns 0x2A.
REQ-035 WR GLB 0x1, WR 0x00 data 0x00 -> slv_en[0] stays 1, err stays 0; WR GLB 0x0, repeat WR -> slv_en[0]=0.
REQ-036 Drive slv_avail channel2=0x20, RD 0x48 two cycles later -> cmd_data_o=0x20; WR 0x48 -> err=1, STAT unchanged.
REQ-037 RD 0x0C (NUM_SLV=3) -> cmd_data_o=0, next RD GLB returns 0x2, following RD GLB returns 0x0; WR unmapped on same edge as GLB RD -> err remains 1.
REQ-038 WR 0x00 then assert rstn=0 for one cycle during following RD -> all outputs back to reset values, cmd_data_o=0.
